sparse_pack: RTL and testbench

// Downstream stage of post_sparsity. Takes one 16-lane fixed-point activation vector plus its keep mask,
// and compacts the surviving non-zero lanes into the low-order lanes of the output, in ascending lane order.

---
 rtl/sparse_pack.sv | 150 +++++++++++++++
 tb/tb_sparse_pack.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sparse_pack.sv
// sparse_pack: serial compaction of a sparse fixed-point activation vector.
//
// A vector of N signed lanes and its keep mask are captured in IDLE. PACK then walks the
// captured lanes one per cycle, in ascending order. Each lane that is both kept and non-zero
// is appended to the low end of o_data, and its o_mask bit is set. After lane N-1 the block
// sits in DONE with stable outputs until the consumer acknowledges with output_taken.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   i_im[N]       signed input lanes, IL+FL bits each
//   i_mask        keep mask, bit k=1 retains lane k
//   input_ready   new vector valid, sampled only in IDLE
//   output_taken  result consumed, sampled only in DONE
//   o_data[N]     packed lanes; o_data[0..o_count-1] valid, remaining lanes zero
//   o_mask        effective mask: i_mask[k] && i_im[k] != 0
//   o_count       number of packed lanes, 0..N
//   state         00 IDLE, 01 PACK, 10 DONE
module sparse_pack #(
  parameter int unsigned IL = 8,
  parameter int unsigned FL = 12,
  parameter int unsigned N  = 16,
  localparam int unsigned W   = IL + FL,
  localparam int unsigned p_N = $clog2(N),
  localparam int unsigned c_N = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   i_im [N],
  input  logic [N-1:0]   i_mask,
  input  logic           input_ready,
  input  logic           output_taken,
  output logic [W-1:0]   o_data [N],
  output logic [N-1:0]   o_mask,
  output logic [c_N-1:0] o_count,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPack = 2'b01,
    StDone = 2'b10,
    StBad  = 2'b11
  } state_e;

  localparam logic [p_N-1:0] LastIdx = p_N'(N - 1);

  state_e state_q, state_d;

  logic [W-1:0]   data_q [N];
  logic [W-1:0]   data_d [N];
  logic [N-1:0]   mask_q, mask_d;
  logic [c_N-1:0] count_q, count_d;
  logic [p_N-1:0] idx_q, idx_d;
  logic [W-1:0]   cap_im_q [N];
  logic [W-1:0]   cap_im_d [N];
  logic [N-1:0]   cap_mask_q, cap_mask_d;

  logic [W-1:0]   lane;
  logic           lane_keep;

  assign lane      = cap_im_q[idx_q];
  assign lane_keep = cap_mask_q[idx_q] && (lane != '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (input_ready) state_d = StPack;
      StPack: if (idx_q == LastIdx) state_d = StDone;
      // input_ready is deliberately ignored here, so a simultaneous request cannot
      // capture on the same edge that releases the result.
      StDone: if (output_taken) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state; everything holds unless the current state says otherwise.
  always_comb begin
    data_d     = data_q;
    mask_d     = mask_q;
    count_d    = count_q;
    idx_d      = idx_q;
    cap_im_d   = cap_im_q;
    cap_mask_d = cap_mask_q;
    case (state_q)
      StIdle: begin
        if (input_ready) begin
          cap_im_d   = i_im;
          cap_mask_d = i_mask;
          for (int k = 0; k < N; k++) begin
            data_d[k] = '0;
          end
          mask_d  = '0;
          count_d = '0;
          idx_d   = '0;
        end
      end
      StPack: begin
        if (lane_keep) begin
          // count_q < N whenever a lane is written, so its low bits address o_data.
          data_d[count_q[p_N-1:0]] = lane;
          mask_d[idx_q]            = 1'b1;
          count_d                  = count_q + c_N'(1);
        end
        idx_d = (idx_q == LastIdx) ? '0 : idx_q + p_N'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        data_q[k]   <= '0;
        cap_im_q[k] <= '0;
      end
      mask_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      cap_mask_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      cap_im_q   <= cap_im_d;
      cap_mask_q <= cap_mask_d;
    end
  end

  // Outputs
  always_comb begin
    o_data  = data_q;
    o_mask  = mask_q;
    o_count = count_q;
    state   = state_q;
  end

endmodule

// File: tb/tb_sparse_pack.sv
// Bench for sparse_pack: scoreboard of expected packed results, pushed on capture and
// popped when the DUT reaches DONE, plus handshake, latency and asynchronous-reset checks.
module tb_sparse_pack;

  localparam int N = 16;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] i_im [N];
  logic [N-1:0] i_mask;
  logic         input_ready;
  logic         output_taken;
  logic [W-1:0] o_data [N];
  logic [N-1:0] o_mask;
  logic [4:0]   o_count;
  logic [1:0]   state;

  sparse_pack dut (
    .clk          (clk),
    .reset        (reset),
    .i_im         (i_im),
    .i_mask       (i_mask),
    .input_ready  (input_ready),
    .output_taken (output_taken),
    .o_data       (o_data),
    .o_mask       (o_mask),
    .o_count      (o_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data [N];
    logic [N-1:0] mask;
    logic [4:0]   count;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [W-1:0] vec [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: append kept, non-zero lanes in ascending order.
  function automatic exp_t model(input logic [W-1:0] im [N], input logic [N-1:0] m);
    exp_t e;
    int   cnt = 0;
    for (int k = 0; k < N; k++) e.data[k] = '0;
    e.mask = '0;
    for (int k = 0; k < N; k++) begin
      if (m[k] && im[k] != '0) begin
        e.data[cnt] = im[k];
        e.mask[k]   = 1'b1;
        cnt++;
      end
    end
    e.count = 5'(cnt);
    return e;
  endfunction

  task automatic run_vec(input logic [W-1:0] im [N], input logic [N-1:0] m,
                         input bit hold_ready, input bit pulse_taken, input string name);
    int   edges;
    exp_t e;
    @(negedge clk);
    i_im        = im;
    i_mask      = m;
    input_ready = 1'b1;
    sb.push_back(model(im, m));
    @(posedge clk);
    #1;
    if (!hold_ready) begin
      input_ready = 1'b0;
    end else begin
      // Captured copy must be immune to later input changes.
      for (int k = 0; k < N; k++) i_im[k] = W'($urandom);
      i_mask = N'($urandom);
    end
    check({name, "_pack"}, 32'(state), 32'h1);
    edges = 0;
    while (state != 2'b10 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      output_taken = (pulse_taken && edges == 3);
      if (pulse_taken && edges == 5) check({name, "_taken_in_pack"}, 32'(state), 32'h1);
    end
    output_taken = 1'b0;
    check({name, "_latency"}, 32'(edges), 32'd16);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      if (state == 2'b10) begin
        check({name, "_count"}, 32'(o_count), 32'(e.count));
        check({name, "_mask"}, 32'(o_mask), 32'(e.mask));
        for (int k = 0; k < N; k++)
          check($sformatf("%s_d%0d", name, k), 32'(o_data[k]), 32'(e.data[k]));
        // DONE holds
        @(posedge clk);
        #1;
        check({name, "_done_hold"}, 32'(state), 32'h2);
        check({name, "_done_count"}, 32'(o_count), 32'(e.count));
        // Release; with hold_ready both handshakes are high on this edge.
        output_taken = 1'b1;
        @(posedge clk);
        #1;
        output_taken = 1'b0;
        input_ready  = 1'b0;
        check({name, "_release"}, 32'(state), 32'h0);
        check({name, "_idle_count"}, 32'(o_count), 32'(e.count));
        check({name, "_idle_mask"}, 32'(o_mask), 32'(e.mask));
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    input_ready  = 1'b0;
    output_taken = 1'b0;
    i_mask       = '0;
    for (int k = 0; k < N; k++) i_im[k] = '0;
    #1;
    check("rst_state", 32'(state), 32'h0);
    check("rst_count", 32'(o_count), 32'h0);
    check("rst_mask", 32'(o_mask), 32'h0);
    check("rst_d0", 32'(o_data[0]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // output_taken in IDLE is ignored
    output_taken = 1'b1;
    @(posedge clk);
    #1;
    output_taken = 1'b0;
    check("idle_taken", 32'(state), 32'h0);

    for (int k = 0; k < N; k++) vec[k] = W'(k + 1);
    run_vec(vec, 16'hFFFF, 1'b0, 1'b0, "dense");
    run_vec(vec, 16'hA5A5, 1'b0, 1'b0, "a5a5");

    for (int k = 0; k < N; k++) vec[k] = (k == 2 || k == 9) ? '0 : 20'hFFFFB;
    run_vec(vec, 16'hFFFF, 1'b0, 1'b0, "neg5");
    run_vec(vec, 16'h0000, 1'b0, 1'b0, "empty");

    for (int k = 0; k < N; k++) vec[k] = W'(3 * k + 7);
    run_vec(vec, 16'h3C0F, 1'b1, 1'b1, "hshake");

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++)
        vec[k] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      run_vec(vec, N'($urandom), 1'b0, 1'b0, $sformatf("rnd%0d", r));
    end

    // Asynchronous reset while PACK is at idx=7
    for (int k = 0; k < N; k++) vec[k] = W'(k + 1);
    @(negedge clk);
    i_im        = vec;
    i_mask      = 16'hFFFF;
    input_ready = 1'b1;
    @(posedge clk);
    #1;
    input_ready = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_count", 32'(o_count), 32'd7);
    reset = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'h0);
    check("arst_count", 32'(o_count), 32'h0);
    check("arst_mask", 32'(o_mask), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(state), 32'h0);
    for (int k = 0; k < N; k++) vec[k] = W'(100 + k);
    run_vec(vec, 16'h8001, 1'b0, 1'b0, "post_rst");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
